// File: rtl/hamming_stream_encoder_pkg.sv
// Shared types and width helpers for the multi-cycle Hamming(7,4)/SECDED(8,4) stream encoder.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Codeword bit positions: parity at Hamming positions 1,2,4 (bits 0,1,3).
    localparam int P1_BIT   = 0;
    localparam int P2_BIT   = 1;
    localparam int D0_BIT   = 2;
    localparam int P4_BIT   = 3;
    localparam int D1_BIT   = 4;
    localparam int D2_BIT   = 5;
    localparam int D3_BIT   = 6;
    localparam int PALL_BIT = 7;

    function automatic int cw_of(input int secded);
        return 7 + ((secded != 0) ? 1 : 0);
    endfunction

    function automatic int enc_w_of(input int data_w, input int secded);
        return (data_w / 4) * cw_of(secded);
    endfunction

    function automatic int nbeats_of(input int data_w, input int lanes);
        return data_w / (4 * lanes);
    endfunction

endpackage

// File: rtl/hamming_stream_encoder_if.sv
// Input word handshake and registered encoded-output handshake of the stream encoder.
interface hamming_stream_encoder_if
    import hamming_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int SECDED = 0
);
    localparam int ENC_W = enc_w_of(DATA_W, SECDED);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [ENC_W-1:0]  encoded_data;
    logic [15:0]       word_count;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, encoded_data, word_count
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, encoded_data, word_count
    );

endinterface

// File: rtl/hamming_stream_encoder_lane.sv
// One nibble encoder lane: 4 data bits to a 7-bit Hamming codeword, plus overall parity when SECDED.
module hamming74_lane
    import hamming_pkg::*;
#(
    parameter int SECDED = 0,
    parameter int CW     = cw_of(SECDED)
) (
    input  logic [3:0]    nib,
    output logic [CW-1:0] cw
);
    logic [6:0] c7;

    always_comb begin
        c7         = '0;
        c7[D0_BIT] = nib[0];
        c7[D1_BIT] = nib[1];
        c7[D2_BIT] = nib[2];
        c7[D3_BIT] = nib[3];
        c7[P1_BIT] = nib[0] ^ nib[1] ^ nib[3];
        c7[P2_BIT] = nib[0] ^ nib[2] ^ nib[3];
        c7[P4_BIT] = nib[1] ^ nib[2] ^ nib[3];
    end

    generate
        if (SECDED != 0) begin : g_secded
            assign cw = {^c7, c7};
        end else begin : g_plain
            assign cw = c7;
        end
    endgenerate

endmodule

// File: rtl/hamming_stream_encoder.sv
// Multi-cycle Hamming encoder: accepts a word, encodes LANES nibbles per enabled beat,
// then holds the encoded word on a valid/ready output until consumed.
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int LANES  = 4,
    parameter int SECDED = 0
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic                     enable,
    hamming_stream_encoder_if.slave bus
);
    localparam int CW       = cw_of(SECDED);
    localparam int ENC_W    = enc_w_of(DATA_W, SECDED);
    localparam int NBEATS   = nbeats_of(DATA_W, LANES);
    localparam int BEAT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int SLAB_IN  = 4 * LANES;
    localparam int SLAB_OUT = CW * LANES;

    generate
        if (LANES < 1 || DATA_W < 4 || (DATA_W % (4 * LANES)) != 0) begin : g_param_err
            $error("hamming_stream_encoder: DATA_W must be a positive multiple of 4*LANES");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic [DATA_W-1:0]   data_q;
    logic [ENC_W-1:0]    enc_q;
    logic [15:0]         wc_q;
    logic                accept, beat_en, out_hs, last_beat;

    logic [LANES-1:0][3:0]    lane_nib;
    logic [LANES-1:0][CW-1:0] lane_cw;

    // Lane l always handles nibble beat*LANES+l, so each beat is one contiguous slab.
    assign lane_nib  = data_q[int'(beat_q) * SLAB_IN +: SLAB_IN];
    assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        hamming74_lane #(.SECDED(SECDED)) u_lane (
            .nib (lane_nib[l]),
            .cw  (lane_cw[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid && enable) state_d = BUSY;
            BUSY:    if (enable && last_beat)    state_d = DONE;
            DONE:    if (bus.out_ready)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The output handshake is deliberately not gated by enable.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && enable;
        bus.out_valid = (state_q == DONE);
        accept        = (state_q == IDLE) && enable && bus.in_valid;
        beat_en       = (state_q == BUSY) && enable;
        out_hs        = (state_q == DONE) && bus.out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            data_q <= '0;
            enc_q  <= '0;
            wc_q   <= '0;
        end else begin
            if (accept) begin
                data_q <= bus.data_in;
                enc_q  <= '0;
                beat_q <= '0;
            end else if (beat_en) begin
                enc_q[int'(beat_q) * SLAB_OUT +: SLAB_OUT] <= lane_cw;
                beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
            end
            if (out_hs) wc_q <= wc_q + 16'd1;
        end
    end

    assign bus.encoded_data = enc_q;
    assign bus.word_count   = wc_q;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Scoreboarded bench: default encoder under random traffic, plus SECDED and single-lane instances.
module tb_hamming_stream_encoder;

    localparam int NBEATS0 = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    hamming_stream_encoder_if #(.DATA_W(128), .SECDED(0)) bus0();
    hamming_stream_encoder_if #(.DATA_W(128), .SECDED(1)) bus1();
    hamming_stream_encoder_if #(.DATA_W(16),  .SECDED(0)) bus2();

    hamming_stream_encoder #(.DATA_W(128), .LANES(4), .SECDED(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus0));
    hamming_stream_encoder #(.DATA_W(128), .LANES(4), .SECDED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus1));
    hamming_stream_encoder #(.DATA_W(16), .LANES(1), .SECDED(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus2));

    int n_chk = 0;
    int n_pass = 0;
    int wc_exp = 0;
    logic [255:0] exp_q[$];
    logic [255:0] mon_e;

    // Reference: data bits sit at Hamming positions 3,5,6,7; parity at 2^k covers positions with bit k set.
    function automatic logic [7:0] ref_cw(input logic [3:0] d, input int secded);
        int dpos[4] = '{3, 5, 6, 7};
        logic [7:0] c = '0;
        logic p;
        for (int i = 0; i < 4; i++) c[dpos[i]-1] = d[i];
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int i = 0; i < 4; i++) if ((dpos[i] & (1 << k)) != 0) p = p ^ d[i];
            c[(1 << k) - 1] = p;
        end
        if (secded != 0) c[7] = ^c[6:0];
        return c;
    endfunction

    function automatic logic [255:0] ref_word(input logic [127:0] d, input int data_w, input int secded);
        logic [255:0] r = '0;
        logic [7:0] c;
        int cw = 7 + secded;
        for (int i = 0; i < data_w / 4; i++) begin
            c = ref_cw(d[4*i +: 4], secded);
            for (int b = 0; b < cw; b++) r[i*cw + b] = c[b];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops the scoreboard on every output handshake of the default instance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("word_count_track", 256'(bus0.word_count), 256'(wc_exp[15:0]));
                if (bus0.out_valid) begin
                    chk("in_ready_while_valid", 256'(bus0.in_ready), 256'(0));
                    if (bus0.out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            $display("FAIL unexpected_word: actual %0h required none", bus0.encoded_data);
                        end else begin
                            mon_e = exp_q.pop_front();
                            chk("encoded_word", 256'(bus0.encoded_data), mon_e);
                        end
                        wc_exp++;
                    end
                end
            end
        end
    end

    task automatic accept0(input logic [127:0] d);
        int n = 0;
        while (!bus0.in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin n_chk++; $display("FAIL accept_timeout: in_ready low %0d cycles, required high", n); end
        bus0.in_valid = 1'b1;
        bus0.data_in  = d;
        exp_q.push_back(ref_word(d, 128, 0));
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        bus0.data_in  = rnd128();
    endtask

    task automatic wait_out0(input int stall_at, input int stall_len, output int lat);
        lat = 0;
        while (!bus0.out_valid && lat < 200) begin
            enable = !(stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
            @(posedge clk); #1;
            lat++;
        end
        enable = 1'b1;
    endtask

    task automatic drain0();
        int n = 0;
        while (bus0.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin n_chk++; $display("FAIL drain_timeout: out_valid stuck %0d cycles, required low", n); end
    endtask

    task automatic run1(input logic [127:0] d, output int lat);
        int n = 0;
        while (!bus1.in_ready && n < 100) begin @(posedge clk); #1; n++; end
        bus1.in_valid = 1'b1;
        bus1.data_in  = d;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run2(input logic [15:0] d, output int lat);
        int n = 0;
        while (!bus2.in_ready && n < 100) begin @(posedge clk); #1; n++; end
        bus2.in_valid = 1'b1;
        bus2.data_in  = d;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        lat = 0;
        while (!bus2.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    initial begin
        int lat, wc0, sa, sl;
        logic [127:0] d;
        logic [255:0] w, held;
        logic seen;

        bus0.in_valid = 1'b0; bus0.data_in = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.data_in = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.data_in = '0; bus2.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 256'(bus0.out_valid), 256'(0));
        chk("rst_encoded", 256'(bus0.encoded_data), 256'(0));
        chk("rst_word_count", 256'(bus0.word_count), 256'(0));
        chk("rst_in_ready_en0", 256'(bus0.in_ready), 256'(0));
        enable = 1'b1; #1;
        chk("rst_in_ready_en1", 256'(bus0.in_ready), 256'(1));
        chk("rst_encoded_secded", 256'(bus1.encoded_data), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All-0x5 word: every field is the codeword of 0x5
        d = {32{4'h5}};
        accept0(d);
        wait_out0(0, 0, lat);
        chk("latency_basic", 256'(lat), 256'(NBEATS0));
        w = '0;
        for (int i = 0; i < 32; i++) w[i*7 +: 7] = 7'h2D;
        chk("fields_0x5", 256'(bus0.encoded_data), w);
        drain0();
        chk("word_count_first", 256'(bus0.word_count), 256'(1));

        // Same word with enable low for 3 cycles mid-BUSY
        accept0(d);
        wait_out0(3, 3, lat);
        chk("latency_stall3", 256'(lat), 256'(NBEATS0 + 3));
        drain0();

        // Consumer back-pressure in DONE; input pulses must be ignored
        bus0.out_ready = 1'b0;
        accept0(rnd128());
        wait_out0(0, 0, lat);
        chk("latency_hold", 256'(lat), 256'(NBEATS0));
        held = 256'(bus0.encoded_data);
        wc0  = int'(bus0.word_count);
        for (int i = 0; i < 5; i++) begin
            bus0.in_valid = 1'($urandom_range(0, 1));
            bus0.data_in  = rnd128();
            @(posedge clk); #1;
            chk("hold_out_valid", 256'(bus0.out_valid), 256'(1));
            chk("hold_encoded", 256'(bus0.encoded_data), held);
            chk("hold_in_ready", 256'(bus0.in_ready), 256'(0));
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", 256'(bus0.out_valid), 256'(0));
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_count_once", 256'(bus0.word_count), 256'(wc0 + 1));
        chk("hold_no_accept", 256'(bus0.out_valid), 256'(0));

        // Handshake completes with enable low in DONE
        bus0.out_ready = 1'b0;
        accept0(rnd128());
        wait_out0(0, 0, lat);
        enable = 1'b0;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_enable_low_hs", 256'(bus0.out_valid), 256'(0));
        chk("idle_enable_low_ready", 256'(bus0.in_ready), 256'(0));
        enable = 1'b1;

        // Asynchronous reset at beat 4 discards the word
        accept0(rnd128());
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 256'(bus0.out_valid), 256'(0));
        chk("midrst_encoded", 256'(bus0.encoded_data), 256'(0));
        chk("midrst_word_count", 256'(bus0.word_count), 256'(0));
        exp_q.delete();
        wc_exp = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; seen = seen | bus0.out_valid; end
        chk("midrst_no_output", 256'(seen), 256'(0));
        accept0(rnd128());
        wait_out0(0, 0, lat);
        chk("post_rst_latency", 256'(lat), 256'(NBEATS0));
        drain0();
        chk("post_rst_count", 256'(bus0.word_count), 256'(1));

        // Random words, stalls and back-pressure
        for (int k = 0; k < 10; k++) begin
            bus0.out_ready = 1'($urandom_range(0, 1));
            sa = int'($urandom_range(0, 7));
            sl = int'($urandom_range(0, 3));
            accept0(rnd128());
            wait_out0(sa, sl, lat);
            chk("latency_random", 256'(lat), 256'(NBEATS0 + sl));
            if (!bus0.out_ready) begin
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                bus0.out_ready = 1'b1;
            end
            drain0();
        end
        chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));

        // SECDED instance: alternating 0x0/0xF nibbles, then all 0x5
        d = {16{8'hF0}};
        run1(d, lat);
        chk("secded_latency", 256'(lat), 256'(NBEATS0));
        w = {16{16'hFF00}};
        chk("secded_alt_literal", 256'(bus1.encoded_data), w);
        chk("secded_alt_model", 256'(bus1.encoded_data), ref_word(d, 128, 1));
        @(posedge clk); #1;
        chk("secded_count", 256'(bus1.word_count), 256'(1));
        d = {32{4'h5}};
        run1(d, lat);
        w = {32{8'h2D}};
        chk("secded_0x5", 256'(bus1.encoded_data), w);
        d = rnd128();
        run1(d, lat);
        chk("secded_random", 256'(bus1.encoded_data), ref_word(d, 128, 1));
        @(posedge clk); #1;

        // Single-lane 16-bit instance
        run2(16'hF0A5, lat);
        chk("lane1_latency", 256'(lat), 256'(4));
        w = 256'(28'hFE0292D);
        chk("lane1_literal", 256'(bus2.encoded_data), w);
        chk("lane1_model", 256'(bus2.encoded_data), ref_word(128'hF0A5, 16, 0));
        @(posedge clk); #1;
        d = 128'($urandom_range(0, 65535));
        run2(d[15:0], lat);
        chk("lane1_random", 256'(bus2.encoded_data), ref_word(d, 16, 0));
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
